// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES-128 decryption sequencer driving one shared
// inverse-round datapath and an external key generator, reusing the schedule for a repeated key.
module aes_dec_round_ctrl #(
    parameter int NR = 10,
    parameter int BW = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BW-1:0]        in_data,
    input  logic [BW-1:0]        in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BW-1:0]        out_data,
    output logic                 kg_start,
    output logic [BW-1:0]        kg_key,
    input  logic                 kg_done,
    input  logic [BW*(NR+1)-1:0] round_keys,
    output logic [BW-1:0]        dp_state,
    output logic [BW-1:0]        dp_rk,
    output logic [1:0]           dp_mode,
    input  logic [BW-1:0]        dp_result,
    output logic                 busy
);
    localparam int RW = $clog2(NR + 1);

    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] st_q, st_d, key_q, key_d;
    logic          key_vld_q, key_vld_d, kg_start_q, kg_start_d;
    logic [RW-1:0] rnd_q, rnd_d, rk_idx;
    logic [BW-1:0] rk [NR+1];

    for (genvar k = 0; k <= NR; k++) begin : g_rk
        assign rk[k] = round_keys[BW*(NR+1)-1-BW*k -: BW];
    end

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        key_d      = key_q;
        key_vld_d  = key_vld_q;
        kg_start_d = 1'b0;
        rnd_d      = rnd_q;
        dp_mode    = 2'b00;
        rk_idx     = '0;
        case (state_q)
            IDLE: if (in_valid) begin
                st_d = in_data;
                if (key_vld_q && in_key == key_q) begin
                    state_d = INIT;
                end else begin
                    key_d      = in_key;
                    key_vld_d  = 1'b0;
                    kg_start_d = 1'b1;
                    state_d    = KEXP;
                end
            end
            KEXP: if (kg_done) begin
                key_vld_d = 1'b1;
                state_d   = INIT;
            end
            INIT: begin
                rk_idx  = RW'(NR);
                st_d    = dp_result;
                rnd_d   = RW'(NR - 1);
                state_d = ROUND;
            end
            ROUND: begin
                dp_mode = 2'b01;
                rk_idx  = rnd_q;
                st_d    = dp_result;
                rnd_d   = rnd_q - RW'(1);
                state_d = (rnd_q == RW'(1)) ? FINAL : ROUND;
            end
            FINAL: begin
                dp_mode = 2'b10;
                st_d    = dp_result;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            st_q       <= '0;
            key_q      <= '0;
            key_vld_q  <= 1'b0;
            kg_start_q <= 1'b0;
            rnd_q      <= '0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            key_q      <= key_d;
            key_vld_q  <= key_vld_d;
            kg_start_q <= kg_start_d;
            rnd_q      <= rnd_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_data  = st_q;
    assign dp_state  = st_q;
    assign kg_key    = key_q;
    assign kg_start  = kg_start_q;
    assign dp_rk     = rk[rk_idx];

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl: bench with behavioural AES inverse-round datapath, key generator
// and a full-cipher reference model, driving FIPS-197 vectors plus random blocks.
module tb_aes_dec_round_ctrl;
    localparam int NR = 10;
    localparam int BW = 128;

    logic              clk = 0, rst_n = 0;
    logic              in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [BW-1:0]     in_data = 0, in_key = 0, out_data, kg_key, dp_state, dp_rk, dp_result;
    logic              kg_start, kg_done, busy;
    logic [1:0]        dp_mode;
    logic [BW*11-1:0]  round_keys;

    aes_dec_round_ctrl #(.NR(NR), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .kg_start(kg_start), .kg_key(kg_key), .kg_done(kg_done), .round_keys(round_keys),
        .dp_state(dp_state), .dp_rk(dp_rk), .dp_mode(dp_mode), .dp_result(dp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    // InvShiftRows followed by InvSubBytes; bytes are column-major, byte 0 at the MSB
    function automatic logic [127:0] isr_isb(logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = isb[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] imc(logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
            o[119-32*c -: 8] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
            o[111-32*c -: 8] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
            o[103-32*c -: 8] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
        end
        return o;
    endfunction

    function automatic logic [BW*11-1:0] expand(logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [BW*11-1:0] o;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) w[i] = key[127-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                    rc = xt(rc);
                end
                w[i] = w[i-4] ^ t;
            end
            o[BW*11-1-32*i -: 32] = w[i];
        end
        return o;
    endfunction

    function automatic logic [127:0] rkey(logic [BW*11-1:0] ks, int k);
        return ks[BW*11-1-128*k -: 128];
    endfunction

    function automatic logic [127:0] ref_dec(logic [127:0] ct, logic [127:0] key);
        logic [BW*11-1:0] ks = expand(key);
        logic [127:0] s = ct ^ rkey(ks, 10);
        for (int r = 9; r >= 1; r--) s = imc(isr_isb(s) ^ rkey(ks, r));
        return isr_isb(s) ^ rkey(ks, 0);
    endfunction

    function automatic logic [127:0] dp_fn(logic [127:0] s, logic [127:0] k, logic [1:0] m);
        return m == 2'b00 ? s ^ k : m == 2'b01 ? imc(isr_isb(s) ^ k) : m == 2'b10 ? isr_isb(s) ^ k : '0;
    endfunction

    always_comb dp_result = dp_fn(dp_state, dp_rk, dp_mode);

    // key generator: kg_done drops as soon as the presented key differs from the expanded one
    int           kdelay = 3, kcnt = 0, ks_cnt = 0;
    logic         kdone_q = 0;
    logic [127:0] kdone_key = '1;
    logic [BW*11-1:0] sched = '0;

    always @(posedge clk) begin
        if (kg_start) begin
            sched     <= expand(kg_key);
            kdone_key <= kg_key;
            kcnt      <= kdelay;
            kdone_q   <= 0;
            ks_cnt    <= ks_cnt + 1;
        end else if (kcnt > 0) kcnt <= kcnt - 1;
        else kdone_q <= 1;
    end

    assign kg_done    = kdone_q && (kdone_key == kg_key);
    assign round_keys = sched;

    bit           mvld = 0;
    logic [127:0] mkey = 0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic accept(input logic [127:0] k, input logic [127:0] d);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("accept_timeout", 0, 1);
        in_valid = 1; in_key = k; in_data = d;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic run(input string tag, input logic [127:0] key, input logic [127:0] ct,
                       input logic [127:0] exp, input int dly, input int hold);
        bit nk, kexp_ok, hold_ok;
        int ks0, n, td, lat;
        nk = !mvld || key != mkey;
        kexp_ok = 1; hold_ok = 1;
        kdelay = dly;
        out_ready = hold == 0;
        ks0 = ks_cnt;
        accept(key, ct);
        mvld = 1; mkey = key;
        n = 0; td = -1;
        while (n < 400) begin
            @(negedge clk);
            if (out_valid) break;
            if (nk && td < 0) begin
                if (kg_done) td = n;
                else if (dp_mode != 2'b00 || !busy) kexp_ok = 0;
            end
            @(posedge clk);
            n++;
        end
        lat = nk ? n - (td + 1) : n;
        chk({tag, "_ovalid"}, out_valid, 1);
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_data"}, out_data, exp);
        if (nk) chk({tag, "_kexp_wait"}, kexp_ok, 1);
        for (int i = 0; i < hold; i++) begin
            if (!out_valid || out_data !== exp || in_ready || !busy) hold_ok = 0;
            in_valid = (i % 3 == 0);
            in_data = rnd128();
            in_key = rnd128();
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 1;
        if (hold > 0) chk({tag, "_hold"}, hold_ok, 1);
        @(posedge clk);
        #1;
        chk({tag, "_xfer_ovalid"}, out_valid, 0);
        chk({tag, "_xfer_idle"}, in_ready, 1);
        chk({tag, "_kg_starts"}, ks_cnt - ks0, nk ? 1 : 0);
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [7:0] inv, s;
        logic [127:0] k, c;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
        #23;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_kg_start", kg_start, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_kg_key", kg_key, 0);
        chk("model_c1", ref_dec(C1, K1), P1);
        chk("model_b", ref_dec(C2, K2), P2);
        @(negedge clk) rst_n = 1;

        run("c1", K1, C1, P1, 3, 0);
        run("b_new", K2, C2, P2, 3, 0);
        run("b_reuse", K2, C2, P2, 3, 0);
        run("c1_bp", K1, C1, P1, 3, 20);

        // abort in ROUND with the round counter at 5
        accept(K1, rnd128());
        repeat (5) @(posedge clk);
        #1 chk("mid_round_mode", dp_mode, 2'b01);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_kg_start", kg_start, 0);
        chk("arst_in_ready", in_ready, 1);
        mvld = 0;
        @(negedge clk) rst_n = 1;
        run("after_rst", K1, C1, P1, 3, 0);
        run("slow_kg", K2, C2, P2, 37, 0);

        k = K2;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) k = rnd128();
            c = rnd128();
            run("rand", k, c, ref_dec(c, k), $urandom_range(0, 6), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
